validator_scheduler: RTL and testbench
======================================

VALIDATOR_SCHEDULER -- requirements
Module: validator_scheduler

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high.
- validate_req  in  1  one-cycle request to validate a move; sampled only in S_IDLE.
- player  in  1  side to move (0 white, 1 black).
- piece_x, piece_y  in  3 each  source square.
- move_x, move_y  in  3 each  destination square.
- piece_read  in  4  board memory read data: bit3 colour, [2:0] type.
  - Types: 0 empty, 1 pawn, 2 rook, 3 knight, 4 bishop, 5 queen, 6 king, 7 reserved.
- address_validator  out  6  board memory read address {x,y}.
- sub_start  out  6  one-hot start to piece validators; bit index = type-1.
- sub_x, sub_y, sub_mx, sub_my  out  3 each  latched coordinates forwarded to validators.
- sub_address  in  36  six 6-bit validator addresses; slice [6i+5:6i] belongs to validator i.
- sub_complete  in  6  validator completion pulses.
- sub_valid  in  6  validator results; sampled with sub_complete.
- busy  out  1  high from the accepted request until done.
- done  out  1  one-cycle completion pulse.
- move_valid  out  1  result; held until the next accepted request.
- error  out  1  timeout or reserved type; held like move_valid.

Function
REQ-002 States SHALL be S_IDLE, S_READ_SRC, S_READ_DST, S_CHECK, S_DISPATCH, S_WAIT_SUB, S_DONE.
REQ-003 In S_IDLE with validate_req=1, the block SHALL latch the coordinates and player, clear move_valid and error, and go to S_READ_SRC.
REQ-004 validate_req SHALL be ignored in every state except S_IDLE.
REQ-005 Board memory read latency SHALL be one cycle: address driven in cycle N, piece_read valid in cycle N+1.
REQ-006 S_READ_SRC SHALL drive {piece_x,piece_y} and go to S_READ_DST.
REQ-007 S_READ_DST SHALL drive {move_x,move_y}, latch piece_read as src_code, and go to S_CHECK.
REQ-008 S_CHECK SHALL latch piece_read as dst_code.
REQ-009 S_CHECK SHALL go to S_DONE with move_valid=0 if any of the following holds:
- src type = 0;
- src colour != player;
- dst type != 0 and dst colour = player;
- source square = destination square.
REQ-010 If src type = 7, S_CHECK SHALL go to S_DONE with move_valid=0 and error=1.
REQ-011 Otherwise S_CHECK SHALL go to S_DISPATCH.
REQ-012 In S_DISPATCH, sub_start[type-1] SHALL be 1 for exactly one cycle, then the block SHALL go to S_WAIT_SUB.
REQ-013 From S_DISPATCH through S_WAIT_SUB, address_validator SHALL equal the sub_address slice of the dispatched validator.
REQ-014 In every other state, address_validator SHALL be driven by the block itself; it SHALL be 0 in S_IDLE and S_DONE.
REQ-015 In S_WAIT_SUB, the first cycle with sub_complete[type-1]=1 SHALL latch move_valid = sub_valid[type-1] and go to S_DONE.
REQ-016 sub_complete and sub_valid bits of non-dispatched validators SHALL be ignored.
REQ-017 A 6-bit timeout counter SHALL clear on entry to S_WAIT_SUB and increment every cycle in it.
REQ-018 When the timeout counter reaches 63 without completion, the block SHALL set move_valid=0 and error=1 and go to S_DONE.
REQ-019 If completion and count=63 coincide, completion SHALL win and error SHALL stay 0.
REQ-020 S_DONE SHALL assert done for one cycle and return to S_IDLE; busy SHALL be 0 in S_IDLE only.
REQ-021 sub_x, sub_y, sub_mx and sub_my SHALL stay stable from request acceptance until the return to S_IDLE.
REQ-022 Request-to-done latency SHALL be 4 cycles for rejected moves; for dispatched moves it SHALL be 6 + the validator's completion delay.

Reset
REQ-023 Asserting reset at any time, including mid-validation, SHALL immediately force S_IDLE and clear the outputs:
- busy=0, done=0, sub_start=0, move_valid=0, error=0;
- address_validator=0;
- timeout counter=0, latched coordinates=0.
REQ-024 The first request after reset deasserts SHALL be processed normally.

Verification
REQ-025 White rook move: src (0,0)=0x2, dst (0,5)=0x0, player=0; rook completes after 3 cycles with valid=1 -> sub_start=6'b000010 one cycle; done with move_valid=1, error=0.
REQ-026 Same-colour capture: src=0x3, dst=0x1, player=0 -> done 4 cycles after request, move_valid=0, sub_start never asserted.
REQ-027 Wrong side: src=0xA (black rook), player=0 -> move_valid=0, error=0, no dispatch.
REQ-028 Timeout: bishop dispatched, sub_complete held 0 -> done 64 cycles after entry to S_WAIT_SUB, move_valid=0, error=1; sub_complete[0] pulses during the wait are ignored.
REQ-029 Busy rejection and reset mid-operation:
- validate_req pulsed while busy -> ignored;
- reset in S_WAIT_SUB -> busy=0 and address_validator=0 immediately;
- the next request completes normally.

Source files
------------

// File: rtl/validator_scheduler_if.sv
// Signal bundle between validator_scheduler, its requester, the board memory
// and the six piece validators.
interface validator_scheduler_if;
  logic        validate_req;
  logic        player;
  logic [2:0]  piece_x;
  logic [2:0]  piece_y;
  logic [2:0]  move_x;
  logic [2:0]  move_y;
  logic [3:0]  piece_read;
  logic [5:0]  address_validator;
  logic [5:0]  sub_start;
  logic [2:0]  sub_x;
  logic [2:0]  sub_y;
  logic [2:0]  sub_mx;
  logic [2:0]  sub_my;
  logic [35:0] sub_address;
  logic [5:0]  sub_complete;
  logic [5:0]  sub_valid;
  logic        busy;
  logic        done;
  logic        move_valid;
  logic        error;

  modport slave (
    input  validate_req, player, piece_x, piece_y, move_x, move_y,
    input  piece_read, sub_address, sub_complete, sub_valid,
    output address_validator, sub_start, sub_x, sub_y, sub_mx, sub_my,
    output busy, done, move_valid, error
  );

  modport master (
    output validate_req, player, piece_x, piece_y, move_x, move_y,
    output piece_read, sub_address, sub_complete, sub_valid,
    input  address_validator, sub_start, sub_x, sub_y, sub_mx, sub_my,
    input  busy, done, move_valid, error
  );
endinterface

// File: rtl/validator_scheduler.sv
// Move-validation scheduler: reads source/destination squares, applies the generic
// ownership checks, then hands the move to the matching piece validator with a timeout.
module validator_scheduler (
  input  logic                  clk,
  input  logic                  reset,
  validator_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_SRC, S_READ_DST, S_CHECK, S_DISPATCH, S_WAIT_SUB, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        player_q;
  logic [2:0]  px, py, mx, my;
  logic [3:0]  src_code;
  logic [5:0]  timeout_cnt;
  logic        move_valid_q, error_q;

  logic [2:0]  src_type;
  logic [5:0]  sel_onehot, sel_addr;
  logic        sel_complete, sel_valid;
  logic        reject, reserved;
  logic [5:0]  addr;
  logic [5:0]  start;
  logic        busy, done;
  logic        finish, finish_valid, finish_error;

  assign src_type = src_code[2:0];

  // Route the dispatched validator's address, completion and result by piece type.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_onehot   = '0;
    sel_addr     = '0;
    sel_complete = 1'b0;
    sel_valid    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (src_type == 3'(i + 1)) begin
        sel_onehot[i] = 1'b1;
        sel_addr      = bus.sub_address[6*i +: 6];
        sel_complete  = bus.sub_complete[i];
        sel_valid     = bus.sub_valid[i];
      end
    end
  end

  // piece_read carries the destination code during S_CHECK.
  assign reserved = (src_type == 3'd7);
  assign reject   = (src_type == 3'd0) ||
                    (src_code[3] != player_q) ||
                    ((bus.piece_read[2:0] != 3'd0) && (bus.piece_read[3] == player_q)) ||
                    ({px, py} == {mx, my});

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    addr         = '0;
    start        = '0;
    busy         = 1'b1;
    done         = 1'b0;
    finish       = 1'b0;
    finish_valid = 1'b0;
    finish_error = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.validate_req) state_nxt = S_READ_SRC;
      end
      S_READ_SRC: begin
        addr      = {px, py};
        state_nxt = S_READ_DST;
      end
      S_READ_DST: begin
        addr      = {mx, my};
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        addr = {mx, my};
        if (reserved) begin
          finish       = 1'b1;
          finish_error = 1'b1;
          state_nxt    = S_DONE;
        end else if (reject) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        addr      = sel_addr;
        start     = sel_onehot;
        state_nxt = S_WAIT_SUB;
      end
      S_WAIT_SUB: begin
        addr = sel_addr;
        // Completion takes priority over a coincident timeout.
        if (sel_complete) begin
          finish       = 1'b1;
          finish_valid = sel_valid;
          state_nxt    = S_DONE;
        end else if (timeout_cnt == 6'd63) begin
          finish       = 1'b1;
          finish_error = 1'b1;
          state_nxt    = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_q     <= 1'b0;
      px           <= '0;
      py           <= '0;
      mx           <= '0;
      my           <= '0;
      src_code     <= '0;
      timeout_cnt  <= '0;
      move_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.validate_req) begin
        player_q     <= bus.player;
        px           <= bus.piece_x;
        py           <= bus.piece_y;
        mx           <= bus.move_x;
        my           <= bus.move_y;
        move_valid_q <= 1'b0;
        error_q      <= 1'b0;
      end
      if (state == S_READ_DST) src_code <= bus.piece_read;
      if (state == S_DISPATCH)      timeout_cnt <= '0;
      else if (state == S_WAIT_SUB) timeout_cnt <= timeout_cnt + 6'd1;
      if (finish) begin
        move_valid_q <= finish_valid;
        error_q      <= finish_error;
      end
    end
  end

  assign bus.address_validator = addr;
  assign bus.sub_start         = start;
  assign bus.sub_x             = px;
  assign bus.sub_y             = py;
  assign bus.sub_mx            = mx;
  assign bus.sub_my            = my;
  assign bus.busy              = busy;
  assign bus.done              = done;
  assign bus.move_valid        = move_valid_q;
  assign bus.error             = error_q;

endmodule

// File: tb/tb_validator_scheduler.sv
// Self-checking bench for validator_scheduler: board memory and piece validators are
// modelled here, and each move's outcome is predicted from the move rules.
module tb_validator_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] board [64];

  validator_scheduler_if bus();

  validator_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Board memory with one cycle of read latency.
  always @(posedge clk) bus.piece_read <= board[bus.address_validator];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // delay: cycles after the cycle following sub_start before the validator completes
  // (that is, cycles spent in the wait before completion); -1 = never completes.
  // abort_cyc > 0 asserts reset mid-cycle at that cycle after the request.
  task automatic run_move(input logic [2:0] px, input logic [2:0] py,
                          input logic [2:0] mx, input logic [2:0] my,
                          input logic pl, input logic [3:0] src, input logic [3:0] dst,
                          input int delay, input logic vld, input logic noise,
                          input int abort_cyc);
    logic [3:0]  eff_dst;
    logic [2:0]  t;
    logic        rsv, rej, disp, exp_valid, exp_err, same, hit, aborted;
    logic [5:0]  onehot, exp_addr, start_val;
    logic [35:0] saddr;
    int          exp_lat, done_cyc, start_cyc, n_starts, k;

    same = ({px, py} == {mx, my});
    for (int i = 0; i < 64; i++) board[i] = 4'($urandom);
    board[{px, py}] = src;
    if (!same) board[{mx, my}] = dst;
    eff_dst = same ? src : dst;

    // Reference outcome from the move rules.
    t    = src[2:0];
    rsv  = (t == 3'd7);
    rej  = (t == 3'd0) || (src[3] != pl) ||
           ((eff_dst[2:0] != 3'd0) && (eff_dst[3] == pl)) || same;
    disp = !rsv && !rej;
    saddr = {$urandom, $urandom};
    onehot = '0;
    exp_addr = '0;
    k = 0;
    if (disp) begin
      k        = int'(t) - 1;
      onehot   = 6'd1 << k;
      exp_addr = saddr[6*k +: 6];
    end
    if (!disp) begin
      exp_lat = 4;  exp_valid = 1'b0; exp_err = rsv;
    end else if (delay >= 0 && delay <= 63) begin
      exp_lat = 6 + delay; exp_valid = vld; exp_err = 1'b0;
    end else begin
      exp_lat = 6 + 63; exp_valid = 1'b0; exp_err = 1'b1;
    end

    @(negedge clk);
    bus.validate_req = 1'b1;
    bus.player       = pl;
    bus.piece_x      = px;
    bus.piece_y      = py;
    bus.move_x       = mx;
    bus.move_y       = my;
    bus.sub_address  = saddr;
    bus.sub_complete = '0;
    bus.sub_valid    = '0;

    done_cyc  = -1;
    start_cyc = -1;
    n_starts  = 0;
    start_val = '0;
    aborted   = 1'b0;
    for (int c = 1; c <= 90 && done_cyc < 0 && !aborted; c++) begin
      @(negedge clk);
      check("busy", bus.busy, 1);
      check("sub_coords", {bus.sub_x, bus.sub_y, bus.sub_mx, bus.sub_my}, {px, py, mx, my});
      if (bus.sub_start != '0) begin
        n_starts++;
        start_val = bus.sub_start;
        start_cyc = c;
      end
      if (bus.done) begin
        done_cyc = c;
        check("addr_done", bus.address_validator, 0);
      end else if (start_cyc >= 0) begin
        check("addr_fwd", bus.address_validator, exp_addr);
      end

      if (abort_cyc > 0 && c == abort_cyc) begin
        #2 reset = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.address_validator, 0);
        check("rst_start", bus.sub_start, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", {bus.move_valid, bus.error}, 0);
        check("rst_coords", {bus.sub_x, bus.sub_y, bus.sub_mx, bus.sub_my}, 0);
        bus.validate_req = 1'b0;
        bus.sub_complete = '0;
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        // Stimulus for the rest of this cycle.
        bus.validate_req = noise && !bus.done && ($urandom_range(0, 2) == 0);
        if (noise) begin
          bus.piece_x = 3'($urandom);
          bus.piece_y = 3'($urandom);
          bus.move_x  = 3'($urandom);
          bus.move_y  = 3'($urandom);
          bus.player  = 1'($urandom);
        end
        hit = disp && start_cyc >= 0 && delay >= 0 && c == start_cyc + 1 + delay;
        bus.sub_complete = noise ? 6'($urandom) : 6'd0;
        bus.sub_valid    = 6'($urandom);
        if (disp) begin
          bus.sub_complete[k] = hit;
          if (hit) bus.sub_valid[k] = vld;
        end
      end
    end

    if (!aborted) begin
      check("done_latency", done_cyc, exp_lat);
      check("move_valid", bus.move_valid, exp_valid);
      check("error", bus.error, exp_err);
      check("n_starts", n_starts, {63'd0, disp});
      if (disp) check("sub_start", start_val, onehot);
      bus.validate_req = 1'b0;
      bus.sub_complete = '0;
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_addr", bus.address_validator, 0);
      check("idle_start", bus.sub_start, 0);
      check("held_result", {bus.move_valid, bus.error}, {exp_valid, exp_err});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rx, ry, rmx, rmy;
    logic       rp;
    logic [3:0] rs, rd;

    bus.validate_req = 1'b0;
    bus.player       = 1'b0;
    bus.piece_x      = '0;
    bus.piece_y      = '0;
    bus.move_x       = '0;
    bus.move_y       = '0;
    bus.sub_address  = '0;
    bus.sub_complete = '0;
    bus.sub_valid    = '0;
    for (int i = 0; i < 64; i++) board[i] = '0;

    #1 reset = 1'b1;
    #2;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_start", bus.sub_start, 0);
    check("reset_result", {bus.move_valid, bus.error}, 0);
    check("reset_addr", bus.address_validator, 0);
    check("reset_coords", {bus.sub_x, bus.sub_y, bus.sub_mx, bus.sub_my}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // White rook (0,0)->(0,5), completes three cycles after its start pulse.
    run_move(3'd0, 3'd0, 3'd0, 3'd5, 1'b0, 4'h2, 4'h0, 2, 1'b1, 1'b0, 0);
    // Same-colour capture, wrong side, reserved type, empty source, null move.
    run_move(3'd1, 3'd0, 3'd2, 3'd2, 1'b0, 4'h3, 4'h1, 0, 1'b1, 1'b0, 0);
    run_move(3'd4, 3'd4, 3'd4, 3'd6, 1'b0, 4'hA, 4'h0, 0, 1'b1, 1'b0, 0);
    run_move(3'd2, 3'd3, 3'd5, 3'd3, 1'b0, 4'h7, 4'h0, 0, 1'b1, 1'b0, 0);
    run_move(3'd6, 3'd1, 3'd6, 3'd2, 1'b1, 4'h8, 4'h0, 0, 1'b1, 1'b0, 0);
    run_move(3'd3, 3'd3, 3'd3, 3'd3, 1'b0, 4'h5, 4'h0, 0, 1'b1, 1'b0, 0);
    // Black knight captures a white pawn; validator answers at once with invalid.
    run_move(3'd7, 3'd7, 3'd5, 3'd6, 1'b1, 4'hB, 4'h1, 0, 1'b0, 1'b0, 0);
    // Bishop timeout with stray completions on other validators and busy requests.
    run_move(3'd2, 3'd0, 3'd5, 3'd3, 1'b0, 4'h4, 4'h0, -1, 1'b1, 1'b1, 0);
    // Completion on the last count beats the timeout; one later times out.
    run_move(3'd3, 3'd0, 3'd3, 3'd7, 1'b0, 4'h5, 4'h9, 63, 1'b1, 1'b0, 0);
    run_move(3'd3, 3'd0, 3'd3, 3'd7, 1'b0, 4'h5, 4'h9, 64, 1'b1, 1'b0, 0);
    // Rook with request pulses while busy.
    run_move(3'd0, 3'd7, 3'd6, 3'd7, 1'b0, 4'h2, 4'h0, 5, 1'b1, 1'b1, 0);
    // Reset while waiting on a bishop, then a normal king move.
    run_move(3'd5, 3'd2, 3'd1, 3'd6, 1'b1, 4'hC, 4'h0, -1, 1'b1, 1'b0, 10);
    run_move(3'd4, 3'd0, 3'd4, 3'd1, 1'b0, 4'h6, 4'h0, 1, 1'b1, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      rx  = 3'($urandom);
      ry  = 3'($urandom);
      rmx = 3'($urandom);
      rmy = 3'($urandom);
      rp  = 1'($urandom);
      rs  = 4'($urandom);
      rd  = 4'($urandom);
      if ($urandom_range(0, 3) != 0) rs[3] = rp;
      run_move(rx, ry, rmx, rmy, rp, rs, rd, int'($urandom_range(0, 8)),
               1'($urandom), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
